// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: per-channel handshake states
// and an index-width helper.
package data_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } chan_state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Consumer-side and memory-side bus of the data-memory arbiter.
// master = the arbiter, slave = the thread LSUs plus memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/data_mem_arbiter_rr_pick.sv
// Round-robin find-first: first requester at or after start (wrapping)
// that is not excluded.
module rr_pick
    import data_mem_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  excl,
    input  logic [PW-1:0] start,
    output logic          found,
    output logic [PW-1:0] idx
);
    always_comb begin
        int p;
        found = 1'b0;
        idx   = '0;
        p     = 0;
        for (int k = 0; k < N; k++) begin
            p = int'(start) + k;
            if (p >= N) p = p - N;
            if (!found && req[p] && !excl[p]) begin
                found = 1'b1;
                idx   = p[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Multiplexes per-thread LSU read/write requests onto NUM_CHANNELS memory
// channels with round-robin fairness; relays completion back to the thread.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.master bus
);
    localparam int PW = idx_bits(NUM_CONSUMERS);
    typedef logic [NUM_CONSUMERS-1:0] cmask_t;

    chan_state_t   state   [NUM_CHANNELS];
    chan_state_t   state_n [NUM_CHANNELS];
    logic [PW-1:0] owner   [NUM_CHANNELS];
    logic [PW-1:0] owner_n [NUM_CHANNELS];
    logic [PW-1:0] pick    [NUM_CHANNELS];
    logic [PW-1:0] rr_ptr, rr_n;
    cmask_t        claim, claim_n, claim_granted, req;
    logic [NUM_CHANNELS-1:0] grant;

    logic [NUM_CHANNELS-1:0]                 mrv_n, mwv_n;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_n, mwa_n;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_n;
    cmask_t                                  crr_n, cwr_n;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_n;

    assign req = bus.consumer_read_valid | bus.consumer_write_valid;

    // Lower channels pick first; each one hides its grant from the next.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        cmask_t        ex_in, ex_out;
        logic          found, take;
        logic [PW-1:0] idx;

        if (c == 0) begin : g_first
            assign ex_in = claim;
        end else begin : g_next
            assign ex_in = g_ch[c-1].ex_out;
        end

        rr_pick #(.N(NUM_CONSUMERS), .PW(PW)) u_pick (
            .req(req), .excl(ex_in), .start(rr_ptr), .found(found), .idx(idx)
        );

        assign take     = found && (state[c] == IDLE);
        assign ex_out   = take ? (ex_in | (cmask_t'(1) << idx)) : ex_in;
        assign grant[c] = take;
        assign pick[c]  = idx;

        if (c == NUM_CHANNELS - 1) begin : g_last
            assign claim_granted = ex_out;
        end
    end

    always_comb begin
        logic          any_grant;
        logic [PW-1:0] hi;
        state_n   = state;
        owner_n   = owner;
        claim_n   = claim_granted;
        rr_n      = rr_ptr;
        mrv_n     = bus.mem_read_valid;
        mra_n     = bus.mem_read_address;
        mwv_n     = bus.mem_write_valid;
        mwa_n     = bus.mem_write_address;
        mwd_n     = bus.mem_write_data;
        crr_n     = bus.consumer_read_ready;
        crd_n     = bus.consumer_read_data;
        cwr_n     = bus.consumer_write_ready;
        any_grant = 1'b0;
        hi        = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state[c])
                IDLE: if (grant[c]) begin
                    owner_n[c] = pick[c];
                    if (!any_grant || pick[c] > hi) hi = pick[c];
                    any_grant = 1'b1;
                    // Read wins when a thread raises both.
                    if (bus.consumer_read_valid[pick[c]]) begin
                        mrv_n[c]   = 1'b1;
                        mra_n[c]   = bus.consumer_read_address[pick[c]];
                        state_n[c] = READ_WAIT;
                    end else begin
                        mwv_n[c]   = 1'b1;
                        mwa_n[c]   = bus.consumer_write_address[pick[c]];
                        mwd_n[c]   = bus.consumer_write_data[pick[c]];
                        state_n[c] = WRITE_WAIT;
                    end
                end
                READ_WAIT: if (bus.mem_read_ready[c]) begin
                    mrv_n[c]        = 1'b0;
                    crd_n[owner[c]] = bus.mem_read_data[c];
                    crr_n[owner[c]] = 1'b1;
                    state_n[c]      = READ_RELAY;
                end
                WRITE_WAIT: if (bus.mem_write_ready[c]) begin
                    mwv_n[c]        = 1'b0;
                    cwr_n[owner[c]] = 1'b1;
                    state_n[c]      = WRITE_RELAY;
                end
                READ_RELAY: if (!bus.consumer_read_valid[owner[c]]) begin
                    crr_n[owner[c]]   = 1'b0;
                    claim_n[owner[c]] = 1'b0;
                    state_n[c]        = IDLE;
                end
                WRITE_RELAY: if (!bus.consumer_write_valid[owner[c]]) begin
                    cwr_n[owner[c]]   = 1'b0;
                    claim_n[owner[c]] = 1'b0;
                    state_n[c]        = IDLE;
                end
                default: state_n[c] = IDLE;
            endcase
        end
        if (any_grant) rr_n = (int'(hi) == NUM_CONSUMERS - 1) ? '0 : hi + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= IDLE;
                owner[c] <= '0;
            end
            claim                    <= '0;
            rr_ptr                   <= '0;
            bus.mem_read_valid       <= '0;
            bus.mem_read_address     <= '0;
            bus.mem_write_valid      <= '0;
            bus.mem_write_address    <= '0;
            bus.mem_write_data       <= '0;
            bus.consumer_read_ready  <= '0;
            bus.consumer_read_data   <= '0;
            bus.consumer_write_ready <= '0;
        end else begin
            state                    <= state_n;
            owner                    <= owner_n;
            claim                    <= claim_n;
            rr_ptr                   <= rr_n;
            bus.mem_read_valid       <= mrv_n;
            bus.mem_read_address     <= mra_n;
            bus.mem_write_valid      <= mwv_n;
            bus.mem_write_address    <= mwa_n;
            bus.mem_write_data       <= mwd_n;
            bus.consumer_read_ready  <= crr_n;
            bus.consumer_read_data   <= crd_n;
            bus.consumer_write_ready <= cwr_n;
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: one single-channel and one
// dual-channel instance sharing clock and reset.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.NUM_CHANNELS(1)) if1 ();
    data_mem_arbiter_if #(.NUM_CHANNELS(2)) if2 ();

    data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) u1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) u2 (
        .clk(clk), .reset(reset), .bus(if2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if1.consumer_read_valid = '0;   if1.consumer_read_address = '0;
        if1.consumer_write_valid = '0;  if1.consumer_write_address = '0;
        if1.consumer_write_data = '0;   if1.mem_read_ready = '0;
        if1.mem_read_data = '0;         if1.mem_write_ready = '0;
        if2.consumer_read_valid = '0;   if2.consumer_read_address = '0;
        if2.consumer_write_valid = '0;  if2.consumer_write_address = '0;
        if2.consumer_write_data = '0;   if2.mem_read_ready = '0;
        if2.mem_read_data = '0;         if2.mem_write_ready = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({if1.mem_read_valid, if1.mem_write_valid, if1.mem_read_address, if1.mem_write_address,
             if1.mem_write_data, if1.consumer_read_ready, if1.consumer_write_ready,
             if1.consumer_read_data} !== '0) begin
            errors++; $display("FAIL reset_if1 outputs not all zero");
        end
        checks++;
        if ({if2.mem_read_valid, if2.mem_write_valid, if2.consumer_read_ready,
             if2.consumer_write_ready, if2.consumer_read_data} !== '0) begin
            errors++; $display("FAIL reset_if2 outputs not all zero");
        end
        checks++;
        if (u1.claim !== 4'b0 || u1.rr_ptr !== 2'd0 || u1.state[0] !== IDLE) begin
            errors++; $display("FAIL reset_state claim=%b rr=%0d want 0/0", u1.claim, u1.rr_ptr);
        end
    endtask

    task automatic test_single_read();
        if1.consumer_read_valid[2] = 1'b1;
        if1.consumer_read_address[2] = 8'h10;
        tick();
        checks++;
        if (if1.mem_read_valid !== 1'b1 || if1.mem_read_address[0] !== 8'h10) begin
            errors++; $display("FAIL single_read_req valid=%b addr=%h want 1/10", if1.mem_read_valid, if1.mem_read_address[0]);
        end
        if1.mem_read_ready = 1'b1; if1.mem_read_data[0] = 8'hAB;
        tick();
        if1.mem_read_ready = 1'b0;
        checks++;
        if (if1.consumer_read_ready !== 4'b0100 || if1.consumer_read_data[2] !== 8'hAB || if1.mem_read_valid !== 1'b0) begin
            errors++; $display("FAIL single_read_done rdy=%b data=%h want 0100/ab", if1.consumer_read_ready, if1.consumer_read_data[2]);
        end
        tick();
        checks++;
        if (if1.consumer_read_ready !== 4'b0100) begin
            errors++; $display("FAIL single_read_hold rdy=%b want 0100", if1.consumer_read_ready);
        end
        if1.consumer_read_valid[2] = 1'b0;
        tick();
        checks++;
        if (if1.consumer_read_ready !== 4'b0 || u1.state[0] !== IDLE || u1.claim !== 4'b0 || u1.rr_ptr !== 2'd3) begin
            errors++; $display("FAIL single_read_release rdy=%b claim=%b rr=%0d want 0/0/3", if1.consumer_read_ready, u1.claim, u1.rr_ptr);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] ea, ed;
        logic [3:0] er;
        int e;
        do_reset();
        for (int i = 0; i < 4; i++) if1.consumer_read_address[i] = 8'h40 + 8'(i);
        if1.consumer_read_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            e  = n % 4;
            ea = 8'h40 + 8'(e);
            ed = 8'hC0 + 8'(e);
            er = 4'b0001 << e;
            tick();
            checks++;
            if (if1.mem_read_valid !== 1'b1 || if1.mem_read_address[0] !== ea) begin
                errors++; $display("FAIL fair_grant n=%0d addr=%h want %h", n, if1.mem_read_address[0], ea);
            end
            if1.mem_read_ready = 1'b1; if1.mem_read_data[0] = ed;
            tick();
            if1.mem_read_ready = 1'b0;
            checks++;
            if (if1.consumer_read_ready !== er || if1.consumer_read_data[e] !== ed) begin
                errors++; $display("FAIL fair_done n=%0d rdy=%b want %b", n, if1.consumer_read_ready, er);
            end
            if1.consumer_read_valid[e] = 1'b0;
            tick();
            if1.consumer_read_valid[e] = 1'b1;
        end
        if1.consumer_read_valid = '0;
        tick();
        checks++;
        if (if1.consumer_read_ready !== 4'b0 || if1.mem_read_valid !== 1'b0 || u1.rr_ptr !== 2'd1) begin
            errors++; $display("FAIL fair_end rdy=%b rr=%0d want 0/1", if1.consumer_read_ready, u1.rr_ptr);
        end
    endtask

    task automatic test_two_channel_write();
        if2.consumer_write_address[0] = 8'h20; if2.consumer_write_data[0] = 8'h05;
        if2.consumer_write_address[1] = 8'h21; if2.consumer_write_data[1] = 8'h06;
        if2.consumer_write_valid = 4'b0011;
        tick();
        checks++;
        if (if2.mem_write_valid !== 2'b11 || if2.mem_read_valid !== 2'b00) begin
            errors++; $display("FAIL dual_valid wv=%b rv=%b want 11/00", if2.mem_write_valid, if2.mem_read_valid);
        end
        checks++;
        if (if2.mem_write_address[0] !== 8'h20 || if2.mem_write_data[0] !== 8'h05 ||
            if2.mem_write_address[1] !== 8'h21 || if2.mem_write_data[1] !== 8'h06) begin
            errors++; $display("FAIL dual_payload a0=%h d0=%h a1=%h d1=%h want 20/05/21/06",
                if2.mem_write_address[0], if2.mem_write_data[0], if2.mem_write_address[1], if2.mem_write_data[1]);
        end
        checks++;
        if (u2.claim !== 4'b0011 || u2.rr_ptr !== 2'd2) begin
            errors++; $display("FAIL dual_claim claim=%b rr=%0d want 0011/2", u2.claim, u2.rr_ptr);
        end
        if2.mem_write_ready = 2'b11;
        tick();
        if2.mem_write_ready = 2'b00;
        checks++;
        if (if2.consumer_write_ready !== 4'b0011 || if2.mem_write_valid !== 2'b00) begin
            errors++; $display("FAIL dual_done wr=%b wv=%b want 0011/00", if2.consumer_write_ready, if2.mem_write_valid);
        end
        if2.consumer_write_valid = '0;
        tick();
        checks++;
        if (if2.consumer_write_ready !== 4'b0 || u2.claim !== 4'b0) begin
            errors++; $display("FAIL dual_release wr=%b claim=%b want 0/0", if2.consumer_write_ready, u2.claim);
        end
    endtask

    task automatic test_collision();
        if1.consumer_read_address[3] = 8'h33;
        if1.consumer_write_address[3] = 8'h77; if1.consumer_write_data[3] = 8'h99;
        if1.consumer_read_valid[3] = 1'b1; if1.consumer_write_valid[3] = 1'b1;
        tick();
        checks++;
        if (if1.mem_read_valid !== 1'b1 || if1.mem_write_valid !== 1'b0 || if1.mem_read_address[0] !== 8'h33) begin
            errors++; $display("FAIL coll_read_first rv=%b wv=%b addr=%h want 1/0/33", if1.mem_read_valid, if1.mem_write_valid, if1.mem_read_address[0]);
        end
        if1.mem_read_ready = 1'b1; if1.mem_read_data[0] = 8'hE1;
        tick();
        if1.mem_read_ready = 1'b0;
        tick();
        checks++;
        if (if1.consumer_read_ready !== 4'b1000 || if1.consumer_read_data[3] !== 8'hE1 || if1.mem_write_valid !== 1'b0) begin
            errors++; $display("FAIL coll_relay rdy=%b data=%h wv=%b want 1000/e1/0", if1.consumer_read_ready, if1.consumer_read_data[3], if1.mem_write_valid);
        end
        if1.consumer_read_valid[3] = 1'b0;
        tick();
        checks++;
        if (if1.consumer_read_ready !== 4'b0 || if1.mem_write_valid !== 1'b0) begin
            errors++; $display("FAIL coll_release rdy=%b wv=%b want 0/0", if1.consumer_read_ready, if1.mem_write_valid);
        end
        tick();
        checks++;
        if (if1.mem_write_valid !== 1'b1 || if1.mem_write_address[0] !== 8'h77 || if1.mem_write_data[0] !== 8'h99) begin
            errors++; $display("FAIL coll_write wv=%b addr=%h data=%h want 1/77/99", if1.mem_write_valid, if1.mem_write_address[0], if1.mem_write_data[0]);
        end
        if1.mem_write_ready = 1'b1;
        tick();
        if1.mem_write_ready = 1'b0;
        checks++;
        if (if1.consumer_write_ready !== 4'b1000) begin
            errors++; $display("FAIL coll_write_done wr=%b want 1000", if1.consumer_write_ready);
        end
        if1.consumer_write_valid[3] = 1'b0;
        tick();
        checks++;
        if (if1.consumer_write_ready !== 4'b0 || u1.rr_ptr !== 2'd0) begin
            errors++; $display("FAIL coll_end wr=%b rr=%0d want 0/0", if1.consumer_write_ready, u1.rr_ptr);
        end
    endtask

    task automatic test_reset_mid();
        if1.consumer_read_address[1] = 8'h11;
        if1.consumer_read_valid[1] = 1'b1;
        tick();
        tick();
        checks++;
        if (if1.mem_read_valid !== 1'b1 || u1.state[0] !== READ_WAIT || u1.rr_ptr !== 2'd2) begin
            errors++; $display("FAIL rmid_pre rv=%b rr=%0d want 1/2", if1.mem_read_valid, u1.rr_ptr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if1.consumer_read_address[1] = 8'h12;
        checks++;
        if (if1.mem_read_valid !== 1'b0 || if1.mem_read_address[0] !== 8'h00 || if1.consumer_read_ready !== 4'b0 ||
            u1.claim !== 4'b0 || u1.rr_ptr !== 2'd0 || u1.state[0] !== IDLE) begin
            errors++; $display("FAIL rmid_cleared rv=%b addr=%h claim=%b rr=%0d want 0/00/0/0",
                if1.mem_read_valid, if1.mem_read_address[0], u1.claim, u1.rr_ptr);
        end
        tick();
        checks++;
        if (if1.mem_read_valid !== 1'b1 || if1.mem_read_address[0] !== 8'h12) begin
            errors++; $display("FAIL rmid_fresh rv=%b addr=%h want 1/12", if1.mem_read_valid, if1.mem_read_address[0]);
        end
        if1.mem_read_ready = 1'b1; if1.mem_read_data[0] = 8'h5D;
        tick();
        if1.mem_read_ready = 1'b0;
        checks++;
        if (if1.consumer_read_ready !== 4'b0010 || if1.consumer_read_data[1] !== 8'h5D) begin
            errors++; $display("FAIL rmid_done rdy=%b data=%h want 0010/5d", if1.consumer_read_ready, if1.consumer_read_data[1]);
        end
        if1.consumer_read_valid[1] = 1'b0;
        tick();
    endtask

    task automatic test_long_latency();
        if1.consumer_read_address[0] = 8'h5A;
        if1.consumer_read_valid[0] = 1'b1;
        tick();
        if1.consumer_read_address[0] = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({if1.mem_read_valid, if1.mem_read_address[0], if1.consumer_read_ready[0]} !== {1'b1, 8'h5A, 1'b0}) begin
                errors++; $display("FAIL long_hold cyc=%0d rv=%b addr=%h rdy=%b want 1/5a/0", i,
                    if1.mem_read_valid, if1.mem_read_address[0], if1.consumer_read_ready[0]);
            end
            tick();
        end
        if1.mem_read_ready = 1'b1; if1.mem_read_data[0] = 8'h3C;
        tick();
        if1.mem_read_ready = 1'b0;
        checks++;
        if (if1.consumer_read_ready !== 4'b0001 || if1.consumer_read_data[0] !== 8'h3C || if1.mem_read_valid !== 1'b0) begin
            errors++; $display("FAIL long_done rdy=%b data=%h want 0001/3c", if1.consumer_read_ready, if1.consumer_read_data[0]);
        end
        if1.consumer_read_valid[0] = 1'b0;
        tick();
    endtask

    task automatic test_early_drop();
        if1.consumer_read_address[2] = 8'h2E;
        if1.consumer_read_valid[2] = 1'b1;
        tick();
        if1.consumer_read_valid[2] = 1'b0;
        tick();
        checks++;
        if (if1.mem_read_valid !== 1'b1 || if1.mem_read_address[0] !== 8'h2E) begin
            errors++; $display("FAIL drop_inflight rv=%b addr=%h want 1/2e", if1.mem_read_valid, if1.mem_read_address[0]);
        end
        if1.mem_read_ready = 1'b1; if1.mem_read_data[0] = 8'h77;
        tick();
        if1.mem_read_ready = 1'b0;
        checks++;
        if (if1.consumer_read_ready !== 4'b0100 || if1.consumer_read_data[2] !== 8'h77) begin
            errors++; $display("FAIL drop_done rdy=%b data=%h want 0100/77", if1.consumer_read_ready, if1.consumer_read_data[2]);
        end
        tick();
        checks++;
        if (if1.consumer_read_ready !== 4'b0 || u1.state[0] !== IDLE || u1.claim !== 4'b0 || if1.mem_read_valid !== 1'b0) begin
            errors++; $display("FAIL drop_exit rdy=%b claim=%b rv=%b want 0/0/0", if1.consumer_read_ready, u1.claim, if1.mem_read_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_two_channel_write();
        test_collision();
        test_reset_mid();
        test_long_latency();
        test_early_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sits directly downstream of the compute core's per-thread data-memory ports (one read and one write request pair per thread LSU).
- Multiplexes NUM_CONSUMERS request streams onto NUM_CHANNELS external data-memory channels.
- Uses round-robin fairness and a per-channel handshake state machine.
- Relays read data and completion back to the requesting thread, so multi-cycle memory latency is hidden behind the core's LSU wait states.

Parameters:
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 8, data word width
- NUM_CONSUMERS, 4, number of requesting thread LSUs
- NUM_CHANNELS, 1, number of parallel memory channels; legal range 1..NUM_CONSUMERS

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  [NUM_CONSUMERS]  per-thread read request
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read complete, data valid
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned read data
- consumer_write_valid  in  [NUM_CONSUMERS]  per-thread write request
- consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
- consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write complete
- mem_read_valid  out  [NUM_CHANNELS]  channel read request
- mem_read_address  out  [NUM_CHANNELS][ADDR_BITS]  channel read address
- mem_read_ready  in  [NUM_CHANNELS]  memory read done, data valid this cycle
- mem_read_data  in  [NUM_CHANNELS][DATA_BITS]  memory read data
- mem_write_valid  out  [NUM_CHANNELS]  channel write request
- mem_write_address  out  [NUM_CHANNELS][ADDR_BITS]  channel write address
- mem_write_data  out  [NUM_CHANNELS][DATA_BITS]  channel write data
- mem_write_ready  in  [NUM_CHANNELS]  memory write done

Behaviour:
- All outputs are registered. On reset:
  - every consumer_*_ready, consumer_read_data, mem_*_valid, mem_*_address and mem_write_data is 0
  - all channels go to IDLE, claim mask is 0, round-robin pointer is 0
- Reset asserted mid-transaction aborts it immediately. No memory request survives reset.
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE: scan consumers starting at rr_ptr, wrapping modulo NUM_CONSUMERS. Pick the first consumer that has read_valid or write_valid set and is not in the claim mask.
  - Read is taken if both are set (read wins).
  - Set the claim bit.
  - Register the address (and data for a write) onto the mem port, assert mem_*_valid next edge.
  - Go to READ_WAIT or WRITE_WAIT.
- Same-cycle grants: channels resolve in ascending index order. A consumer claimed by channel c is invisible to channels above c in the same cycle. No consumer is ever served by two channels.
- rr_ptr: after any grant cycle, set to (highest consumer index granted this cycle + 1) mod NUM_CONSUMERS. Unchanged if nothing was granted.
- READ_WAIT: hold mem_read_valid and address until mem_read_ready=1. On that edge:
  - drop mem_read_valid
  - latch mem_read_data into consumer_read_data
  - assert consumer_read_ready
  - go to READ_RELAY
- WRITE_WAIT: same as READ_WAIT, using mem_write_ready. Asserts consumer_write_ready, goes to WRITE_RELAY.
- READ_RELAY / WRITE_RELAY: hold ready (and data) until the consumer deasserts its matching valid. On that edge:
  - clear ready
  - clear the claim bit
  - go to IDLE
- Latency:
  - request sampled at edge t gives mem valid visible after edge t.
  - mem ready at edge k gives consumer ready after edge k.
  - consumer valid low at edge r gives ready low, channel IDLE and consumer re-eligible after edge r.
  - Minimum round trip with 1-cycle memory: 3 cycles.
- Consumer address/data changes while a request is in flight are ignored; values are latched at grant.
- A consumer valid that drops before completion is tolerated. The transaction still completes at memory, and the RELAY state exits on the first cycle valid is low.
- Idle consumers (valid=0) never consume a grant slot.

Decomposition:
- Package data_mem_arbiter_pkg: channel state localparams (IDLE=0, READ_WAIT=1, WRITE_WAIT=2, READ_RELAY=3, WRITE_RELAY=4), 3-bit state type.
- Sub-module rr_pick: combinational round-robin find-first.
  - Inputs: request vector, exclude mask, start pointer.
  - Outputs: found flag and index.
  - Instantiated once per channel, chained through the exclude mask.

Test Plan:
- Single read: NUM_CHANNELS=1. Consumer 2 reads addr 0x10, memory returns 0xAB with 1-cycle ready.
  -> mem_read_address=0x10; consumer_read_ready[2]=1 with data 0xAB; ready clears the cycle after valid drops.
- Fairness: all 4 consumers hold read_valid continuously with 1 channel.
  -> grant order 0,1,2,3,0; no consumer granted twice before all others are served.
- Two channels, simultaneous: consumers 0 and 1 write 0x05→0x20 and 0x06→0x21 in the same cycle.
  -> channel 0 serves consumer 0, channel 1 serves consumer 1, both mem_write_valid high in the same cycle; both consumer_write_ready asserted.
- Read/write collision: consumer 3 asserts both read and write.
  -> read served first; write served only after read_valid drops.
- Reset mid-operation: assert reset while a channel is in READ_WAIT with memory ready withheld.
  -> next edge all valids/readies are 0, claim mask and rr_ptr are 0, and a fresh request is granted normally.
- Long memory latency: mem_read_ready delayed 10 cycles.
  -> mem_read_valid and address held stable throughout; consumer_read_ready asserts exactly 1 cycle after ready.
